// File: rtl/mult_share_pkg.sv
// Shared types and constants for the two-requester multiplier sharing controller.
package mult_share_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_idx_t;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input req_idx_t idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mult_mnbit.sv
// Combinational unsigned M x N array multiplier, full M+N bit product.
// Zero latency; no flow control, callers hold operands stable while it settles.
module mult_mnbit #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [M+N-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) p = p + ((M+N)'(a) << i);
    end
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input arbiter, one-hot grant; round-robin on last_grant when MULT_SHARE_FAIR_EN
// is defined, otherwise fixed priority to requester 0. Purely combinational.
module rr_arb2
  import mult_share_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
`ifdef MULT_SHARE_FAIR_EN
  input  req_idx_t           last_grant,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output req_idx_t           gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    if (req_valid == 2'b11) begin
`ifdef MULT_SHARE_FAIR_EN
      gnt_idx = ~last_grant;
`else
      gnt_idx = 1'b0;
`endif
    end else if (req_valid[1]) begin
      gnt_idx = 1'b1;
    end
    gnt = (req_valid == '0) ? '0 : idx2onehot(gnt_idx);
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one multiplier between two valid/ready requesters (fair arbitration with MULT_SHARE_FAIR_EN).
// Response CALC_CYC+1 cycles after accept; one op in flight, held in RESP until the owner takes it.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int M        = 4,
  parameter int N        = 4,
  parameter int CALC_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [M-1:0]       req_a0,
  input  logic [M-1:0]       req_a1,
  input  logic [N-1:0]       req_b0,
  input  logic [N-1:0]       req_b1,
  output logic [NUM_REQ-1:0] resp_valid,
  input  logic [NUM_REQ-1:0] resp_ready,
  output logic [M+N-1:0]     resp_prod,
  output logic               busy
);

  localparam int            CW       = $clog2(CALC_CYC + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CALC_CYC);

  state_t          state_q;
  logic            idle_q;
  logic [CW-1:0]   cnt_q;
  req_idx_t        owner_q;
  logic [M-1:0]    op_a_q;
  logic [N-1:0]    op_b_q;
  logic [M+N-1:0]  prod_q;
`ifdef MULT_SHARE_FAIR_EN
  req_idx_t        last_grant_q;
`endif

  logic [NUM_REQ-1:0] gnt;
  req_idx_t           gnt_idx;
  logic [M+N-1:0]     mult_p;
  logic               req_fire;
  logic               resp_fire;

  rr_arb2 u_arb (
    .req_valid (req_valid),
`ifdef MULT_SHARE_FAIR_EN
    .last_grant(last_grant_q),
`endif
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  // op_a_q/op_b_q -> prod_q is a CALC_CYC-cycle multicycle path.
  mult_mnbit #(.M(M), .N(N)) u_mult (
    .a(op_a_q),
    .b(op_b_q),
    .p(mult_p)
  );

  // idle_q is a registered IDLE flag that stays low while in reset, keeping req_ready quiet.
  assign req_ready  = idle_q ? (gnt & req_valid) : '0;
  assign req_fire   = |req_ready;
  assign resp_valid = (state_q == RESP) ? idx2onehot(owner_q) : '0;
  assign resp_fire  = (state_q == RESP) && resp_ready[owner_q];
  assign resp_prod  = prod_q;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idle_q       <= 1'b0;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      prod_q       <= '0;
`ifdef MULT_SHARE_FAIR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            state_q      <= CALC;
            idle_q       <= 1'b0;
            cnt_q        <= CNT_LOAD;
            owner_q      <= gnt_idx;
            op_a_q       <= gnt_idx ? req_a1 : req_a0;
            op_b_q       <= gnt_idx ? req_b1 : req_b0;
`ifdef MULT_SHARE_FAIR_EN
            last_grant_q <= gnt_idx;
`endif
          end else begin
            idle_q <= 1'b1;
          end
        end
        CALC: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            prod_q  <= mult_p;
            state_q <= RESP;
          end
        end
        RESP: begin
          // Return through IDLE so a new request never shares the response handshake cycle.
          if (resp_fire) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl (M=N=4, CALC_CYC=2); expectations follow MULT_SHARE_FAIR_EN.
module tb_mult_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready;
  logic [7:0] resp_prod;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  mult_share_ctrl #(.M(4), .N(4), .CALC_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_prod (resp_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 10) begin
      tick();
      #1;
      n++;
    end
  endtask

  // One full operation with resp_ready high; checks grant, latency and product.
  task automatic do_op(input logic [1:0] vld, input logic [1:0] exp_gnt,
                       input logic [7:0] exp_prod, input bit hold, input string tag);
    req_valid  = vld;
    resp_ready = 2'b11;
    wait_ready();
    chk({tag, "_grant"}, req_ready, exp_gnt);
    tick();
    if (!hold) begin
      req_valid = req_valid & ~exp_gnt;
      req_a0 = 4'h0; req_b0 = 4'h0; req_a1 = 4'h0; req_b1 = 4'h0;
    end
    chk({tag, "_busy_t1"}, busy, 1);
    chk({tag, "_rv_t1"}, resp_valid, 0);
    tick();
    chk({tag, "_rv_t2"}, resp_valid, 0);
    tick();
    chk({tag, "_rv_t3"}, resp_valid, exp_gnt);
    chk({tag, "_prod"}, resp_prod, exp_prod);
    tick();
    chk({tag, "_rv_t4"}, resp_valid, 0);
  endtask

  initial begin
    logic [1:0] eg;
    logic [7:0] ep;

    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    req_a0 = 4'h0; req_b0 = 4'h0; req_a1 = 4'h0; req_b1 = 4'h0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_prod", resp_prod, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Single request F x F, operands cleared right after accept.
    req_a0 = 4'hF; req_b0 = 4'hF;
    do_op(2'b01, 2'b01, 8'hE1, 1'b0, "single");
    chk("single_idle_busy", busy, 0);

    // Backpressure: req0 2x3 held in RESP, req1 0xD pending.
    req_a0 = 4'h2; req_b0 = 4'h3; req_a1 = 4'h0; req_b1 = 4'hD;
    resp_ready = 2'b00; req_valid = 2'b01;
    wait_ready();
    chk("bp_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    #1;
    chk("bp_calc_ready", req_ready, 0);
    tick(); tick();
    resp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_rv", resp_valid, 2'b01);
      chk("bp_hold_prod", resp_prod, 8'h06);
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_busy", busy, 1);
      tick();
    end
    resp_ready = 2'b01;
    #1;
    chk("bp_release_rv", resp_valid, 2'b01);
    tick();
    chk("bp_done_rv", resp_valid, 0);
    chk("bp_done_busy", busy, 0);
    #1;
    chk("bp_next_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick(); tick();
    chk("zero_rv", resp_valid, 2'b10);
    chk("zero_prod", resp_prod, 8'h00);
    tick();
    chk("zero_nonowner_ignored", resp_valid, 2'b10);
    resp_ready = 2'b10;
    tick();
    chk("zero_done_rv", resp_valid, 0);

    // Asynchronous reset while in RESP.
    req_a0 = 4'hF; req_b0 = 4'h1; resp_ready = 2'b00; req_valid = 2'b01;
    wait_ready();
    tick();
    req_valid = 2'b00;
    tick(); tick();
    chk("areset_pre_rv", resp_valid, 2'b01);
    chk("areset_pre_prod", resp_prod, 8'h0F);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_req_ready", req_ready, 0);
    chk("areset_resp_valid", resp_valid, 0);
    chk("areset_resp_prod", resp_prod, 0);
    chk("areset_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("areset_after_rv", resp_valid, 0);

    // Ties with both requesters held valid.
    req_a0 = 4'h3; req_b0 = 4'h5; req_a1 = 4'h7; req_b1 = 4'h9;
    for (int i = 0; i < 4; i++) begin
`ifdef MULT_SHARE_FAIR_EN
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      eg = 2'b01;
`endif
      ep = (eg == 2'b01) ? 8'h0F : 8'h3F;
      do_op(2'b11, eg, ep, 1'b1, "tie");
    end
    req_valid = 2'b00;
    tick();

    // Reset pulse during CALC discards the op and reinitialises arbitration.
    req_a0 = 4'h5; req_b0 = 4'h5; req_valid = 2'b01;
    wait_ready();
    chk("calcrst_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    chk("calcrst_busy", busy, 0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("calcrst_no_resp", resp_valid, 0);
    end
    req_a0 = 4'h3; req_b0 = 4'h5; req_a1 = 4'h7; req_b1 = 4'h9;
    do_op(2'b11, 2'b01, 8'h0F, 1'b0, "tie_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencing and arbitration controller that shares one combinational M×N array multiplier between two requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. The controller works in three steps:
- accepts one operation at a time;
- holds the operands stable for a fixed settle window while the multiplier ripples;
- registers the product and returns it to the requester that issued the operation.

It sits between the lab's operand sources (e.g. switch/FSM front ends) and the shared multiplier datapath.

## Interface
Parameters:
- M, 4, width of operand A
- N, 4, width of operand B
- CALC_CYC, 1, settle cycles allowed for the multiplier; must be ≥1

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester request accept; at most one bit high
- req_a0, req_a1  in  M  operand A of requester 0 / 1
- req_b0, req_b1  in  N  operand B of requester 0 / 1
- resp_valid  out  2  one-hot response valid, addressed to the operation owner
- resp_ready  in  2  per-requester response accept
- resp_prod  out  M+N  registered unsigned product, shared by both requesters
- busy  out  1  high in every state except IDLE

## Operation
FSM states and transitions:
- IDLE:
  - The arbiter selects a grant g among the asserted req_valid bits.
  - req_ready[g] is driven combinationally high only while req_valid[g] is high.
  - On handshake: latch op_a/op_b from requester g, set owner = g, load cnt = CALC_CYC, update last_grant = g, go to CALC.
- CALC:
  - op_a/op_b and owner are frozen; req_ready = 0.
  - cnt decrements each cycle.
  - In the cycle cnt == 1: capture prod_q = op_a × op_b (full M+N bits, unsigned, no truncation), go to RESP.
- RESP:
  - resp_valid[owner] = 1; resp_prod = prod_q, stable.
  - Hold until resp_ready[owner] is high, then go to IDLE.
  - resp_ready of the non-owner is ignored.

Arbitration, with the fairness feature compiled in:
- Both valid: grant the requester that is not last_grant.
- One valid: grant that requester.
- last_grant resets to 1, so requester 0 wins the first tie.

Boundary conditions:
- No new request is accepted in the same cycle as the response handshake; IDLE is always visited.
- Requests deasserted before a handshake are not remembered.
- Operand changes after the handshake have no effect.
- Reset mid-operation, in any state: the operation is discarded, no response is issued, and last_grant is reinitialised.
- Products at the extremes: 0×x gives 0; (2^M−1)×(2^N−1) gives the full-width result with the MSB set when M,N ≥ 2.

## Timing
- Reset values:
  - Outputs: req_ready = 0, resp_valid = 0, resp_prod = 0, busy = 0.
  - Internal: state = IDLE, cnt = 0, owner = 0, last_grant = 1.
- Request handshake in cycle t. Then:
  - CALC occupies cycles t+1 … t+CALC_CYC.
  - resp_valid is high from cycle t+CALC_CYC+1.
- Minimum issue-to-issue interval: CALC_CYC+2 cycles, with resp_ready held high.
- The multiplier path from op_a/op_b to prod_q is a CALC_CYC-cycle multicycle path; constrain it accordingly.
- cnt width is $clog2(CALC_CYC+1).

## Configuration
- MULT_SHARE_FAIR_EN defined: round-robin arbitration using last_grant, as specified above.
- MULT_SHARE_FAIR_EN undefined: fixed priority, requester 0 always wins when both are valid; last_grant is not implemented.

## Structure
Shared package mult_share_pkg contains:
- the state typedef (IDLE, CALC, RESP);
- the requester-index typedef (1 bit);
- the constant NUM_REQ = 2.

Sub-modules:
- One sub-module, rr_arb2: two-input arbiter producing a one-hot grant from req_valid and last_grant, compiled fair or fixed according to the macro.
- The team's existing mult_mnbit, instantiated once with (M, N) on op_a/op_b.

## Test plan
Defaults for all scenarios: M = N = 4, CALC_CYC = 2, fairness enabled.
- Reset: assert rst_n = 0 mid-simulation → all outputs 0 asynchronously, before the next clock edge.
- Single request: req_valid = 2'b01, A = 4'hF, B = 4'hF, resp_ready = 1.
  - req_ready[0] high in cycle t;
  - resp_valid = 2'b01 at t+3;
  - resp_prod = 8'hE1.
- Tie from reset: both valid, req0 = 3×5, req1 = 7×9.
  - req0 is served first with 8'h0F;
  - req1 is served next with 8'h3F;
  - a third tie grants req0 again.
- Backpressure: resp_ready = 0 for 5 cycles in RESP → resp_valid and resp_prod hold, req_ready = 0, busy = 1 throughout; release completes the transfer and returns to IDLE.
- Reset in CALC: pulse rst_n low during the cycle after acceptance → no resp_valid ever appears for that operation; the next tie grants req0.
- MULT_SHARE_FAIR_EN undefined: both requesters are held valid for 4 operations → every grant goes to req0; req1 is never served.
